// File: rtl/oser_multi.sv
// Multi-lane soft serializer: CH words of W bits per frame, one bit per clk_i, with frame-aligned pclk_o/frame_o.
// Optional OSER_TRAIN_EN macro adds train_i, which substitutes TRAIN_PAT on every lane at frame boundaries.
module oser_multi #(
  parameter int             CH        = 4,
  parameter int             W         = 7,
  parameter logic [W-1:0]   IDLE      = '0,
  parameter bit             MSB_FIRST = 1'b0
`ifdef OSER_TRAIN_EN
  , parameter logic [W-1:0] TRAIN_PAT = W'(16'h5555)
`endif
) (
  input  logic            clk_i,
  input  logic            nrst_i,
  input  logic [CH*W-1:0] par_i,
  input  logic            valid_i,
`ifdef OSER_TRAIN_EN
  input  logic            train_i,
`endif
  output logic            ready_o,
  output logic [CH-1:0]   q_o,
  output logic            pclk_o,
  output logic            frame_o,
  output logic            underflow_o,
  output logic [15:0]     ufl_cnt_o
);

  localparam int CW   = $clog2(W);
  localparam int HALF = (W + 1) / 2;

  // Reorders a word so that bit s is always the bit sent in slot s.
  function automatic logic [W-1:0] orderWord(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = MSB_FIRST ? w[W-1-i] : w[i];
    return r;
  endfunction

  localparam logic [W-1:0] IDLE_ORD = orderWord(IDLE);

  logic [CW-1:0]          r_cnt;
  logic [CH-1:0][W-1:0]   r_sh;
  logic [CH-1:0]          r_q;
  logic                   r_pclk;
  logic                   r_frame;
  logic [CH*W-1:0]        r_buf;
  logic                   r_bufFull;
  logic                   r_armed;
  logic                   r_ufl;
  logic [15:0]            r_uflCnt;

  logic                   w_boundary;
  logic                   w_accept;
  logic                   w_consume;
  logic                   w_underflow;
  logic [CW-1:0]          w_nextCnt;
  logic [CH*W-1:0]        w_lanes;
  logic [CH-1:0][W-1:0]   w_ord;

  assign w_boundary = (r_cnt == CW'(W - 1));
  assign w_accept   = valid_i && !r_bufFull;
  assign w_nextCnt  = w_boundary ? '0 : r_cnt + CW'(1);

  // Word selected for the next frame; only meaningful on the boundary cycle.
  always_comb begin
    w_lanes     = {CH{IDLE}};
    w_consume   = 1'b0;
    w_underflow = 1'b0;
`ifdef OSER_TRAIN_EN
    if (train_i) w_lanes = {CH{TRAIN_PAT}};
    else
`endif
    if (r_bufFull) begin
      w_lanes   = r_buf;
      w_consume = w_boundary;
    end else begin
      w_underflow = w_boundary && r_armed;
    end
  end

  always_comb begin
    w_ord = '0;
    for (int k = 0; k < CH; k++) w_ord[k] = orderWord(w_lanes[k*W +: W]);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_cnt   <= '0;
      r_pclk  <= 1'b1;
      r_frame <= 1'b1;
      for (int k = 0; k < CH; k++) begin
        r_sh[k] <= IDLE_ORD;
        r_q[k]  <= IDLE_ORD[0];
      end
    end else begin
      r_cnt   <= w_nextCnt;
      r_pclk  <= (w_nextCnt < CW'(HALF));
      r_frame <= (w_nextCnt == '0);
      // r_sh bit 0 always holds the bit currently on q_o.
      for (int k = 0; k < CH; k++) begin
        if (w_boundary) begin
          r_sh[k] <= w_ord[k];
          r_q[k]  <= w_ord[k][0];
        end else begin
          r_sh[k] <= r_sh[k] >> 1;
          r_q[k]  <= r_sh[k][1];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_buf     <= '0;
      r_bufFull <= 1'b0;
      r_armed   <= 1'b0;
    end else if (w_accept) begin
      r_buf     <= par_i;
      r_bufFull <= 1'b1;
      r_armed   <= 1'b1;
    end else if (w_consume) begin
      r_bufFull <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_ufl    <= 1'b0;
      r_uflCnt <= '0;
    end else begin
      r_ufl <= w_underflow;
      if (w_underflow && (r_uflCnt != 16'hFFFF)) r_uflCnt <= r_uflCnt + 16'd1;
    end
  end

  assign ready_o     = !r_bufFull;
  assign q_o         = r_q;
  assign pclk_o      = r_pclk;
  assign frame_o     = r_frame;
  assign underflow_o = r_ufl;
  assign ufl_cnt_o   = r_uflCnt;

endmodule

// File: tb/tb_oser_multi.sv
// Directed bench for oser_multi (CH=2, W=7): one LSB-first and one MSB-first instance.
// Training checks are compiled only when OSER_TRAIN_EN is defined.
module tb_oser_multi;

  localparam int CH = 2;
  localparam int W  = 7;

  logic            clk_i = 1'b0;
  logic            nrst_i;
  logic [CH*W-1:0] par0, par1;
  logic            valid0, valid1;
  logic            ready0, ready1;
  logic [CH-1:0]   q0, q1;
  logic            pclk0, pclk1, frame0, frame1, ufl0, ufl1;
  logic [15:0]     uflCnt0, uflCnt1;
`ifdef OSER_TRAIN_EN
  logic            train0 = 1'b0;
  logic            train1 = 1'b0;
`endif

  int vecCount = 0;
  int errCount = 0;
  int slot     = 0;

  logic [W-1:0] a0, a1, m0, m1, b0, b1, c0, c1, pa, pb, tp;

  always #5 clk_i = ~clk_i;

  oser_multi #(.CH(CH), .W(W), .IDLE('0), .MSB_FIRST(1'b0)) dut0 (
    .clk_i(clk_i), .nrst_i(nrst_i), .par_i(par0), .valid_i(valid0),
`ifdef OSER_TRAIN_EN
    .train_i(train0),
`endif
    .ready_o(ready0), .q_o(q0), .pclk_o(pclk0), .frame_o(frame0),
    .underflow_o(ufl0), .ufl_cnt_o(uflCnt0)
  );

  oser_multi #(.CH(CH), .W(W), .IDLE('0), .MSB_FIRST(1'b1)) dut1 (
    .clk_i(clk_i), .nrst_i(nrst_i), .par_i(par1), .valid_i(valid1),
`ifdef OSER_TRAIN_EN
    .train_i(train1),
`endif
    .ready_o(ready1), .q_o(q1), .pclk_o(pclk1), .frame_o(frame1),
    .underflow_o(ufl1), .ufl_cnt_o(uflCnt1)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s (slot %0d): got %0h expected %0h", tag, slot, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
    slot = (slot == W - 1) ? 0 : slot + 1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [CH*W-1:0] p0, input logic v1, input logic [CH*W-1:0] p1);
    valid0 = v0;
    par0   = p0;
    valid1 = v1;
    par1   = p1;
  endtask

  task automatic doReset();
    nrst_i = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    repeat (2) @(posedge clk_i);
    #1;
    nrst_i = 1'b1;
    slot   = 0;
  endtask

  task automatic waitSlot(input int s);
    for (int i = 0; i < W && slot != s; i++) nextCycle();
  endtask

  function automatic logic [W-1:0] streamWord(input int f, input int lane);
    return (lane == 0) ? W'(f * 23 + 9) : W'(f * 41 + 3);
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    a0 = 7'h55;      a1 = 7'h0F;
    m0 = 7'b1000000; m1 = 7'b0000011;
    b0 = 7'b0110010; b1 = 7'b1101001;
    c0 = 7'h7F;      c1 = 7'h7F;
    tp = 7'h55;

    // Reset state and unarmed idle frames.
    doReset();
    checkOutput("rst_ready", ready0, 1);
    checkOutput("rst_uflcnt", uflCnt0, 0);
    for (int i = 0; i < 2 * W; i++) begin
      checkOutput("idle_q", q0, 0);
      checkOutput("idle_pclk", pclk0, slot < 4);
      checkOutput("idle_frame", frame0, slot == 0);
      checkOutput("idle_ufl", ufl0, 0);
      nextCycle();
    end
    checkOutput("idle_uflcnt", uflCnt0, 0);

    // Word A at slot 2 on both instances; word B accepted on the boundary cycle.
    waitSlot(2);
    applyStimulus(1'b1, {a1, a0}, 1'b1, {m1, m0});
    nextCycle();
    applyStimulus(1'b0, {a1, a0}, 1'b0, {m1, m0});
    checkOutput("held_ready", ready0, 0);
    waitSlot(0);
    checkOutput("lat_ready", ready0, 1);
    checkOutput("lat_ufl", ufl0, 0);
    for (int s = 0; s < W; s++) begin
      checkOutput("wordA_q", q0, {a1[s], a0[s]});
      checkOutput("msb_q", q1, {m1[W-1-s], m0[W-1-s]});
      checkOutput("wordA_frame", frame0, s == 0);
      if (s == W - 1) applyStimulus(1'b1, {b1, b0}, 1'b0, '0);
      nextCycle();
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("bnd_idle_q", q0, 0);
    checkOutput("bnd_ufl", ufl0, 1);
    checkOutput("bnd_uflcnt", uflCnt0, 1);
    checkOutput("bnd_ready", ready0, 0);
    checkOutput("msb_ufl", ufl1, 1);
    nextCycle();
    checkOutput("bnd_ufl_pulse", ufl0, 0);
    waitSlot(0);
    for (int s = 0; s < 5; s++) begin
      checkOutput("wordB_q", q0, {b1[s], b0[s]});
      applyStimulus(s == 1, {c1, c0}, 1'b0, '0);
      nextCycle();
    end
    applyStimulus(1'b0, '0, 1'b0, '0);

    // Asynchronous reset mid-frame, with word C buffered.
    checkOutput("pre_rst_q", q0, {b1[5], b0[5]});
    checkOutput("pre_rst_pclk", pclk0, 0);
    checkOutput("pre_rst_ready", ready0, 0);
    checkOutput("pre_rst_uflcnt", uflCnt0, 1);
    #2 nrst_i = 1'b0;
    #1;
    checkOutput("arst_q", q0, 0);
    checkOutput("arst_pclk", pclk0, 1);
    checkOutput("arst_frame", frame0, 1);
    checkOutput("arst_ready", ready0, 1);
    checkOutput("arst_uflcnt", uflCnt0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    nrst_i = 1'b1;
    slot   = 0;
    for (int i = 0; i < W; i++) nextCycle();
    checkOutput("post_rst_q", q0, 0);
    checkOutput("post_rst_ufl", ufl0, 0);
    checkOutput("post_rst_uflcnt", uflCnt0, 0);

    // valid held high: one accept per frame, no underflow, words in order.
    doReset();
    valid0 = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int s = 0; s < W; s++) begin
        if (s == 0) par0 = {streamWord(f, 1), streamWord(f, 0)};
        checkOutput("str_ready", ready0, s == 0);
        checkOutput("str_ufl", ufl0, 0);
        if (f > 0) begin
          pa = streamWord(f - 1, 0);
          pb = streamWord(f - 1, 1);
          checkOutput("str_q", q0, {pb[s], pa[s]});
        end
        nextCycle();
      end
    end
    valid0 = 1'b0;
    checkOutput("str_uflcnt", uflCnt0, 0);

`ifdef OSER_TRAIN_EN
    // Three training frames hold the buffered word back.
    doReset();
    waitSlot(2);
    applyStimulus(1'b1, {a1, a0}, 1'b0, '0);
    nextCycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    train0 = 1'b1;
    waitSlot(0);
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < W; s++) begin
        checkOutput("train_q", q0, {tp[s], tp[s]});
        checkOutput("train_ready", ready0, 0);
        checkOutput("train_uflcnt", uflCnt0, 0);
        if (f == 2 && s == 1) train0 = 1'b0;
        nextCycle();
      end
    end
    for (int s = 0; s < W; s++) begin
      checkOutput("post_train_q", q0, {a1[s], a0[s]});
      nextCycle();
    end
    checkOutput("post_train_ufl", ufl0, 1);
    checkOutput("post_train_uflcnt", uflCnt0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/oser_multi.md
# oser_multi

Parametrised multi-channel soft serializer with a generated pixel clock. It takes CH parallel words of W bits per frame through a valid/ready handshake and shifts them out one bit per clock on CH lanes. It produces a frame-aligned pclk_o (duty ⌈W/2⌉/W) and a frame strobe. It sits between video/pattern logic and the output pins. It replaces fixed 7:1 serializer bring-up logic and its hand-built 3.5-divider clock.

## Interface
- CH, 4: number of serial lanes.
- W, 7: bits per word / serialization ratio; legal range 2..16.
- IDLE, {W{1'b0}}: W-bit word sent on every lane when no data is available.
- MSB_FIRST, 0: 0 = bit 0 sent first; 1 = bit W-1 sent first.
- TRAIN_PAT, alternating 1010… (bit 0 = 1), W bits: training word. Used only with OSER_TRAIN_EN.

- clk_i  in  1  bit clock (fast clock); all logic is on its rising edge.
- nrst_i  in  1  asynchronous, active-low reset.
- par_i  in  CH*W  lane k word = par_i[k*W +: W].
- valid_i  in  1  par_i holds a word.
- ready_o  out  1  a one-entry holding buffer is empty.
- q_o  out  CH  registered serial lanes.
- pclk_o  out  1  registered frame clock, high for bit slots 0..⌈W/2⌉-1.
- frame_o  out  1  registered, high during bit slot 0.
- underflow_o  out  1  one-cycle pulse when IDLE is loaded after arming.
- ufl_cnt_o  out  16  saturating underflow count.
- train_i  in  1  present only with OSER_TRAIN_EN.

## Operation
- Bit counter cnt counts 0..W-1 and wraps. The boundary is the edge where cnt==W-1.
- Handshake: a word is accepted when valid_i && ready_o. ready_o = !buf_full; it has no combinational path from valid_i.
- Accepted words go to the holding buffer, never straight to the shift registers.
- At the boundary, each lane's shift register loads one of:
  - the buffer word, if buf_full; buf_full is then cleared.
  - otherwise IDLE.
- Accept on the boundary cycle while the buffer is empty: the word enters the buffer. The boundary loads IDLE, counted as underflow if armed. The word is sent next frame.
- Accept on the boundary cycle while the buffer is full: impossible, because ready_o=0.
- Arming: the armed flag is set by the first accepted word after reset. Until armed, IDLE loads do not flag underflow.
- Underflow: underflow_o pulses for 1 cycle, aligned with bit slot 0 of the IDLE frame. ufl_cnt_o increments and saturates at 16'hFFFF.
- Bit order: lane bit for slot s is word[s] if MSB_FIRST=0, else word[W-1-s].
- All lanes always load on the same boundary and carry the same bit slot.

## Timing
- Reset values:
  - cnt=0; shift registers hold IDLE.
  - q_o = IDLE bit for slot 0 on all lanes.
  - pclk_o=1, frame_o=1.
  - ready_o=1, buf_full=0, armed=0.
  - underflow_o=0, ufl_cnt_o=0.
- Reset mid-frame: all state returns to the values above immediately. The partial word and any buffered word are discarded.
- q_o, pclk_o and frame_o are registered and mutually aligned. In the cycle with slot s on q_o, pclk_o=(s<⌈W/2⌉) and frame_o=(s==0).
- Latency, empty buffer: a word accepted in slot c appears at slot 0 of the next frame, W-c cycles later. An accept in slot W-1 waits one full extra frame.
- ready_o rises the cycle after the boundary that drained the buffer.
- Throughput: one word per W cycles sustained.

## Configuration
- OSER_TRAIN_EN defined:
  - train_i exists.
  - If train_i=1 at a boundary, every lane loads TRAIN_PAT. The buffer is not consumed and underflow is not flagged.
  - train_i is sampled only at boundaries.
- OSER_TRAIN_EN undefined: no train_i port, no TRAIN_PAT logic; behaviour is otherwise identical.

## Test plan
- Reset, W=7, CH=2, IDLE=0, no valid: q_o=0; pclk_o pattern 1111000 repeating; frame_o every 7 cycles; underflow_o never pulses (not armed).
- Single word lane0=7'h55, lane1=7'h0F accepted at slot 2: lane0 emits 1,0,1,0,1,0,1 and lane1 emits 1,1,1,1,0,0,0 starting at the next slot 0 (5 cycles later). The following frame is IDLE with underflow_o=1 and ufl_cnt_o=1.
- valid_i held high continuously: after the buffer fills, ready_o pulses once per 7 cycles; there are no underflows and no lost or duplicated words.
- MSB_FIRST=1, word 7'b1000000: bit 1 appears in slot 0.
- Accept exactly on the slot-6 cycle with the buffer empty: an IDLE frame follows (underflow counted), then the word is sent.
- OSER_TRAIN_EN, train_i=1 for 3 frames: three frames of 1010101 are sent; the buffered word is held and sent afterwards; ufl_cnt_o is unchanged.
- Async reset asserted mid-frame: outputs return to reset values with no clock edge required.
